// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch unit: the fetch FSM state
// encoding, the NOP word used for bubbles, the sequential PC step and the
// default reset PC.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,   // request outstanding at PC
      HOLD  = 2'd1,   // word captured, downstream stalled
      DRAIN = 2'd2    // waiting out the response to a cancelled request
   } fetch_state_e;

   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam int unsigned PC_STEP          = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-cache request/response handshake.
//   icache_req   : fetch request (master -> slave)
//   icache_addr  : word-aligned fetch address (master -> slave)
//   icache_ready : response valid this cycle (slave -> master)
//   icache_data  : instruction word, valid with icache_ready (slave -> master)
// A response is consumed only in a cycle where req and ready are both high.
// -----------------------------------------------------------------------------
interface if_fetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              icache_req;
   logic [ADDR_W-1:0] icache_addr;
   logic              icache_ready;
   logic [DATA_W-1:0] icache_data;

   modport master (
      output icache_req,
      output icache_addr,
      input  icache_ready,
      input  icache_data
   );

   modport slave (
      input  icache_req,
      input  icache_addr,
      output icache_ready,
      output icache_data
   );
endinterface

// File: rtl/fetch_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf
// One-entry buffer holding {Inst, PC_Plus4} for a word that returned from the
// cache while the pipeline was stalled.
//   clock, rst        : clock, synchronous active-high reset
//   load              : capture inst_in / pc_plus4_in (wins over clear)
//   clear             : empty the entry
//   inst_in           : instruction word to capture
//   pc_plus4_in       : PC of that word plus 4
//   inst_out          : buffered instruction
//   pc_plus4_out      : buffered PC+4
// -----------------------------------------------------------------------------
module fetch_hold_buf #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] inst_in,
   input  logic [ADDR_W-1:0] pc_plus4_in,
   output logic [DATA_W-1:0] inst_out,
   output logic [ADDR_W-1:0] pc_plus4_out
);

   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;

   // NOTE: every signal written here is given a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      inst_d     = inst_q;
      pc_plus4_d = pc_plus4_q;
      if (load) begin
         inst_d     = inst_in;
         pc_plus4_d = pc_plus4_in;
      end else if (clear) begin
         inst_d     = '0;
         pc_plus4_d = '0;
      end
   end

   // NOTE: unlike a RAM array, this single entry is reset so its contents are
   // defined from the first cycle; flops are updated with non-blocking
   // assignments so every register samples its pre-edge inputs.
   always_ff @(posedge clock) begin
      if (rst) begin
         inst_q     <= '0;
         pc_plus4_q <= '0;
      end else begin
         inst_q     <= inst_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign inst_out     = inst_q;
   assign pc_plus4_out = pc_plus4_q;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Producer side of the IF/ID pipeline register. Owns the PC, fetches words
// from the instruction cache and hands each one, with its PC+4, to IF/ID.
// Handles hazard stalls (PCWrite=0), branch redirects from EX and cache-miss
// latency (bubbles while a miss is outstanding).
//
// Ports:
//   clock, rst     : clock, synchronous active-high reset (wins over all)
//   PCWrite        : 0 = hazard stall, hold PC and current instruction
//   branch_taken   : one-cycle redirect strobe, wins over PCWrite
//   branch_target  : redirect address (bits [1:0] ignored)
//   icache         : if_fetch_unit_if.master, req/addr out, ready/data in
//   Inst           : instruction to IF/ID (registered)
//   PC_Plus4       : PC of Inst plus 4 (registered)
//   IFIDWrite      : IF/ID load enable (registered)
//   flush          : IF/ID clear strobe (registered)
//
// Optional build macro IF_FETCH_PERF_EN adds saturating counters:
//   perf_miss_cycles : cycles with icache_req=1 and icache_ready=0
//   perf_flushes     : number of flush strobes
// -----------------------------------------------------------------------------
module if_fetch_unit
   import if_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              PCWrite,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   if_fetch_unit_if.master   icache,
   output logic [DATA_W-1:0] Inst,
   output logic [ADDR_W-1:0] PC_Plus4,
   output logic              IFIDWrite,
   output logic              flush
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]       perf_miss_cycles,
   output logic [31:0]       perf_flushes
`endif
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
   logic              ifid_write_q, ifid_write_d;
   logic              flush_q, flush_d;

   logic              req;
   logic              ready;
   logic [ADDR_W-1:0] pc_next_seq;
   logic [ADDR_W-1:0] target_aligned;

   logic              buf_load;
   logic              buf_clear;
   logic [DATA_W-1:0] buf_inst;
   logic [ADDR_W-1:0] buf_pc_plus4;

   // Request side decodes straight from state and PC. While draining, the
   // cancelled address stays on the bus because the cache cannot drop it.
   assign req            = (state_q != HOLD);
   assign ready          = icache.icache_ready;
   assign icache.icache_req  = req;
   assign icache.icache_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

   // Addition wraps modulo 2^ADDR_W, so 0xFFFF_FFFC + 4 gives 0.
   assign pc_next_seq    = pc_q + ADDR_W'(PC_STEP);
   assign target_aligned = branch_target & ALIGN_MASK;

   fetch_hold_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_hold_buf (
      .clock        (clock),
      .rst          (rst),
      .load         (buf_load),
      .clear        (buf_clear),
      .inst_in      (icache.icache_data),
      .pc_plus4_in  (pc_next_seq),
      .inst_out     (buf_inst),
      .pc_plus4_out (buf_pc_plus4)
   );

   // Inst / PC_Plus4 only change when IF/ID is written; otherwise they hold.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      inst_d       = inst_q;
      pc_plus4_d   = pc_plus4_q;
      ifid_write_d = 1'b0;
      flush_d      = 1'b0;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;

      if (branch_taken) begin
         // Redirect: flush IF/ID, drop anything captured or arriving.
         flush_d   = 1'b1;
         pc_d      = target_aligned;
         buf_clear = 1'b1;
         case (state_q)
            FETCH: begin
               if (!ready) begin
                  // Request still in flight: remember its address so it can
                  // be held on the bus until the cache answers.
                  state_d      = DRAIN;
                  drain_addr_d = pc_q;
               end else begin
                  state_d = FETCH;
               end
            end
            // A further redirect while draining keeps the old request on the
            // bus; if it completes in this very cycle there is nothing left
            // to drain.
            DRAIN:   state_d = ready ? FETCH : DRAIN;
            default: state_d = FETCH;
         endcase
      end else begin
         case (state_q)
            FETCH: begin
               if (ready) begin
                  if (PCWrite) begin
                     ifid_write_d = 1'b1;
                     inst_d       = icache.icache_data;
                     pc_plus4_d   = pc_next_seq;
                     pc_d         = pc_next_seq;
                  end else begin
                     buf_load = 1'b1;
                     state_d  = HOLD;
                  end
               end else if (PCWrite) begin
                  ifid_write_d = 1'b1;
                  inst_d       = DATA_W'(NOP_INST);
                  pc_plus4_d   = '0;
               end
            end
            HOLD: begin
               if (PCWrite) begin
                  ifid_write_d = 1'b1;
                  inst_d       = buf_inst;
                  pc_plus4_d   = buf_pc_plus4;
                  pc_d         = pc_next_seq;
                  buf_clear    = 1'b1;
                  state_d      = FETCH;
               end
            end
            DRAIN: begin
               if (PCWrite) begin
                  ifid_write_d = 1'b1;
                  inst_d       = DATA_W'(NOP_INST);
                  pc_plus4_d   = '0;
               end
               if (ready) begin
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC_A;
         drain_addr_q <= '0;
         inst_q       <= '0;
         pc_plus4_q   <= '0;
         ifid_write_q <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         inst_q       <= inst_d;
         pc_plus4_q   <= pc_plus4_d;
         ifid_write_q <= ifid_write_d;
         flush_q      <= flush_d;
      end
   end

   assign Inst      = inst_q;
   assign PC_Plus4  = pc_plus4_q;
   assign IFIDWrite = ifid_write_q;
   assign flush     = flush_q;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_miss_cycles_q, perf_miss_cycles_d;
   logic [31:0] perf_flushes_q, perf_flushes_d;

   // Counted on the same edge that registers the flush strobe; both saturate.
   always_comb begin
      perf_miss_cycles_d = perf_miss_cycles_q;
      perf_flushes_d     = perf_flushes_q;
      if (req && !ready && (perf_miss_cycles_q != '1)) begin
         perf_miss_cycles_d = perf_miss_cycles_q + 32'd1;
      end
      if (flush_d && (perf_flushes_q != '1)) begin
         perf_flushes_d = perf_flushes_q + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         perf_miss_cycles_q <= '0;
         perf_flushes_q     <= '0;
      end else begin
         perf_miss_cycles_q <= perf_miss_cycles_d;
         perf_flushes_q     <= perf_flushes_d;
      end
   end

   assign perf_miss_cycles = perf_miss_cycles_q;
   assign perf_flushes     = perf_flushes_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed scenarios plus a randomized run compared against a transaction-level
// model of the fetch unit. Inputs change 1 time unit after the rising edge;
// outputs are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

   logic        clock;
   logic        rst;
   logic        pcwrite;
   logic        br;
   logic [31:0] tgt;
   logic        rdy;
   logic        data_ovr_en;
   logic [31:0] data_ovr;
   logic [31:0] inst;
   logic [31:0] pc_plus4;
   logic        ifid_write;
   logic        flush;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_miss_cycles;
   logic [31:0] perf_flushes;
`endif

   int total = 0;
   int bad   = 0;

   // Cache contents: a fixed scrambled word per address.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   if_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   assign bus.icache_ready = rdy;
   assign bus.icache_data  = data_ovr_en ? data_ovr : word_of(bus.icache_addr);

   if_fetch_unit #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h0000_0100)
   ) dut (
      .clock         (clock),
      .rst           (rst),
      .PCWrite       (pcwrite),
      .branch_taken  (br),
      .branch_target (tgt),
      .icache        (bus),
      .Inst          (inst),
      .PC_Plus4      (pc_plus4),
      .IFIDWrite     (ifid_write),
      .flush         (flush)
`ifdef IF_FETCH_PERF_EN
      ,
      .perf_miss_cycles (perf_miss_cycles),
      .perf_flushes     (perf_flushes)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_in(input bit pcw, input bit b, input logic [31:0] t, input bit r);
      pcwrite = pcw;
      br      = b;
      tgt     = t;
      rdy     = r;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   // Reset dominates a simultaneous hit and redirect.
   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b1, 1'b1, 32'h0000_0800, 1'b1);
      tick();
      tick();
      rst = 1'b0;
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      total++; if (bus.icache_req !== 1'b1) begin bad++; $display("FAIL reset_req: got %b expected 1", bus.icache_req); end
      total++; if (bus.icache_addr !== 32'h100) begin bad++; $display("FAIL reset_addr: got %h expected 00000100", bus.icache_addr); end
      total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h expected 0", inst); end
      total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL reset_pc4: got %h expected 0", pc_plus4); end
      total++; if (ifid_write !== 1'b0) begin bad++; $display("FAIL reset_ifidwrite: got %b expected 0", ifid_write); end
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b expected 0", flush); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a = 32'h100 + 32'(4 * i);
         set_in(1'b1, 1'b0, 32'h0, 1'b1);
         total++; if (bus.icache_addr !== a) begin bad++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, bus.icache_addr, a); end
         tick();
         total++; if (ifid_write !== 1'b1) begin bad++; $display("FAIL b2b_ifidwrite[%0d]: got %b expected 1", i, ifid_write); end
         total++; if (pc_plus4 !== a + 32'd4) begin bad++; $display("FAIL b2b_pc4[%0d]: got %h expected %h", i, pc_plus4, a + 32'd4); end
         total++; if (inst !== word_of(a)) begin bad++; $display("FAIL b2b_inst[%0d]: got %h expected %h", i, inst, word_of(a)); end
      end
   endtask

   task automatic test_miss();
      do_reset();
      set_in(1'b1, 1'b1, 32'h200, 1'b1);
      tick();
      total++; if (flush !== 1'b1) begin bad++; $display("FAIL miss_setup_flush: got %b expected 1", flush); end
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b0);
         total++; if (bus.icache_addr !== 32'h200 || bus.icache_req !== 1'b1) begin bad++; $display("FAIL miss_addr[%0d]: got req=%b addr=%h expected req=1 addr=00000200", i, bus.icache_req, bus.icache_addr); end
         tick();
         total++; if (ifid_write !== 1'b1 || inst !== 32'h0 || pc_plus4 !== 32'h0) begin bad++; $display("FAIL miss_bubble[%0d]: got wr=%b inst=%h pc4=%h expected wr=1 inst=0 pc4=0", i, ifid_write, inst, pc_plus4); end
      end
      data_ovr_en = 1'b1;
      data_ovr    = 32'h8C01_0004;
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      data_ovr_en = 1'b0;
      total++; if (inst !== 32'h8C01_0004) begin bad++; $display("FAIL miss_inst: got %h expected 8c010004", inst); end
      total++; if (pc_plus4 !== 32'h204 || ifid_write !== 1'b1) begin bad++; $display("FAIL miss_pc4: got pc4=%h wr=%b expected pc4=00000204 wr=1", pc_plus4, ifid_write); end
      total++; if (bus.icache_addr !== 32'h204) begin bad++; $display("FAIL miss_next_addr: got %h expected 00000204", bus.icache_addr); end
   endtask

   task automatic test_stall();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1);
         tick();
         total++; if (ifid_write !== 1'b0 || bus.icache_req !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d]: got wr=%b req=%b expected wr=0 req=0", i, ifid_write, bus.icache_req); end
      end
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      total++; if (ifid_write !== 1'b1 || inst !== word_of(32'h100) || pc_plus4 !== 32'h104) begin bad++; $display("FAIL stall_release: got wr=%b inst=%h pc4=%h expected wr=1 inst=%h pc4=00000104", ifid_write, inst, pc_plus4, word_of(32'h100)); end
      total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h104) begin bad++; $display("FAIL stall_next_addr: got req=%b addr=%h expected req=1 addr=00000104", bus.icache_req, bus.icache_addr); end
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      total++; if (ifid_write !== 1'b1 || inst !== 32'h0) begin bad++; $display("FAIL stall_once: got wr=%b inst=%h expected wr=1 inst=0", ifid_write, inst); end
   endtask

   task automatic test_branch_during_miss();
      do_reset();
      set_in(1'b1, 1'b1, 32'h300, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      set_in(1'b1, 1'b1, 32'h400, 1'b0);
      total++; if (bus.icache_addr !== 32'h300) begin bad++; $display("FAIL bmiss_inflight_addr: got %h expected 00000300", bus.icache_addr); end
      tick();
      total++; if (flush !== 1'b1 || ifid_write !== 1'b0) begin bad++; $display("FAIL bmiss_flush: got flush=%b wr=%b expected flush=1 wr=0", flush, ifid_write); end
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h300) begin bad++; $display("FAIL bmiss_drain_addr: got req=%b addr=%h expected req=1 addr=00000300", bus.icache_req, bus.icache_addr); end
      tick();
      total++; if (flush !== 1'b0 || ifid_write !== 1'b1 || inst !== 32'h0) begin bad++; $display("FAIL bmiss_drain_bubble: got flush=%b wr=%b inst=%h expected flush=0 wr=1 inst=0", flush, ifid_write, inst); end
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      total++; if (inst !== 32'h0) begin bad++; $display("FAIL bmiss_discard: got inst=%h expected 0", inst); end
      total++; if (bus.icache_addr !== 32'h400) begin bad++; $display("FAIL bmiss_new_addr: got %h expected 00000400", bus.icache_addr); end
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      total++; if (inst !== word_of(32'h400) || pc_plus4 !== 32'h404) begin bad++; $display("FAIL bmiss_target_inst: got inst=%h pc4=%h expected inst=%h pc4=00000404", inst, pc_plus4, word_of(32'h400)); end
   endtask

   task automatic test_branch_vs_stall();
      do_reset();
      set_in(1'b0, 1'b1, 32'h502, 1'b1);
      tick();
      total++; if (flush !== 1'b1 || ifid_write !== 1'b0) begin bad++; $display("FAIL bstall_flush: got flush=%b wr=%b expected flush=1 wr=0", flush, ifid_write); end
      total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h500) begin bad++; $display("FAIL bstall_addr: got req=%b addr=%h expected req=1 addr=00000500", bus.icache_req, bus.icache_addr); end
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      total++; if (inst !== word_of(32'h500) || pc_plus4 !== 32'h504) begin bad++; $display("FAIL bstall_next: got inst=%h pc4=%h expected inst=%h pc4=00000504", inst, pc_plus4, word_of(32'h500)); end
   endtask

   task automatic test_wrap();
      do_reset();
      set_in(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      tick();
      total++; if (bus.icache_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h expected fffffffc", bus.icache_addr); end
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      total++; if (pc_plus4 !== 32'h0 || ifid_write !== 1'b1 || inst !== word_of(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_pc4: got pc4=%h wr=%b inst=%h expected pc4=0 wr=1 inst=%h", pc_plus4, ifid_write, inst, word_of(32'hFFFF_FFFC)); end
      total++; if (bus.icache_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr: got %h expected 0", bus.icache_addr); end
   endtask

   task automatic test_reset_mid_miss();
      do_reset();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      total++; if (inst !== word_of(32'h100) || pc_plus4 !== 32'h104) begin bad++; $display("FAIL rmid_pre: got inst=%h pc4=%h expected inst=%h pc4=00000104", inst, pc_plus4, word_of(32'h100)); end
      rst = 1'b1;
      set_in(1'b1, 1'b1, 32'h700, 1'b0);
      tick();
      rst = 1'b0;
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      total++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h100) begin bad++; $display("FAIL rmid_addr: got req=%b addr=%h expected req=1 addr=00000100", bus.icache_req, bus.icache_addr); end
      total++; if (inst !== 32'h0 || pc_plus4 !== 32'h0 || ifid_write !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL rmid_outputs: got inst=%h pc4=%h wr=%b flush=%b expected all 0", inst, pc_plus4, ifid_write, flush); end
   endtask

   // Randomized run against a transaction-level model: the PC, whether a word
   // is parked waiting for the stall to clear, and whether a cancelled request
   // is still owed a response.
   task automatic test_random();
      logic [31:0] m_pc, m_hold_inst, m_hold_pc4, m_drain_addr;
      bit          m_hold, m_drain;
      logic [31:0] e_inst, e_pc4, e_addr;
      bit          e_wr, e_fl, e_req;
      bit          pcw, b, r;
      logic [31:0] t;

      do_reset();
      m_pc = 32'h100; m_hold = 0; m_drain = 0;
      m_hold_inst = '0; m_hold_pc4 = '0; m_drain_addr = '0;
      e_inst = '0; e_pc4 = '0;

      for (int cyc = 0; cyc < 800; cyc++) begin
         pcw = ($urandom_range(0, 9) < 8);
         b   = ($urandom_range(0, 11) == 0);
         r   = ($urandom_range(0, 9) < 6);
         t   = $urandom;
         set_in(pcw, b, t, r);

         e_req  = !m_hold;
         e_addr = m_drain ? m_drain_addr : m_pc;
         total++; if (bus.icache_req !== e_req || bus.icache_addr !== e_addr) begin bad++; $display("FAIL rand_req[%0d]: got req=%b addr=%h expected req=%b addr=%h", cyc, bus.icache_req, bus.icache_addr, e_req, e_addr); end

         e_wr = 0;
         e_fl = 0;
         if (b) begin
            e_fl = 1;
            if (m_drain) begin
               if (r) m_drain = 0;
            end else if (!m_hold && !r) begin
               m_drain      = 1;
               m_drain_addr = m_pc;
            end
            m_hold = 0;
            m_pc   = {t[31:2], 2'b00};
         end else if (m_hold) begin
            if (pcw) begin
               e_wr = 1; e_inst = m_hold_inst; e_pc4 = m_hold_pc4;
               m_hold = 0; m_pc = m_pc + 32'd4;
            end
         end else if (m_drain) begin
            if (pcw) begin e_wr = 1; e_inst = '0; e_pc4 = '0; end
            if (r) m_drain = 0;
         end else if (r) begin
            if (pcw) begin
               e_wr = 1; e_inst = word_of(m_pc); e_pc4 = m_pc + 32'd4;
               m_pc = m_pc + 32'd4;
            end else begin
               m_hold = 1; m_hold_inst = word_of(m_pc); m_hold_pc4 = m_pc + 32'd4;
            end
         end else if (pcw) begin
            e_wr = 1; e_inst = '0; e_pc4 = '0;
         end

         tick();
         total++; if (ifid_write !== e_wr || flush !== e_fl) begin bad++; $display("FAIL rand_ctrl[%0d]: got wr=%b flush=%b expected wr=%b flush=%b", cyc, ifid_write, flush, e_wr, e_fl); end
         total++; if (inst !== e_inst || pc_plus4 !== e_pc4) begin bad++; $display("FAIL rand_data[%0d]: got inst=%h pc4=%h expected inst=%h pc4=%h", cyc, inst, pc_plus4, e_inst, e_pc4); end
      end
   endtask

   initial begin
      rst         = 1'b1;
      pcwrite     = 1'b1;
      br          = 1'b0;
      tgt         = 32'h0;
      rdy         = 1'b0;
      data_ovr_en = 1'b0;
      data_ovr    = 32'h0;
      #1;

      test_reset();
      test_back_to_back();
      test_miss();
      test_stall();
      test_branch_during_miss();
      test_branch_vs_stall();
      test_wrap();
      test_reset_mid_miss();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
